// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs decoded instruction descriptions into RV32I words and writes them to imem
module instr_encoder #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [2:0]        in_funct3,
    input  logic              in_f7b5,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FULL
    } state_t;

    localparam logic [3:0] OP_LOAD   = 4'd0;
    localparam logic [3:0] OP_STORE  = 4'd1;
    localparam logic [3:0] OP_RTYPE  = 4'd2;
    localparam logic [3:0] OP_BRANCH = 4'd3;
    localparam logic [3:0] OP_ITYPE  = 4'd4;
    localparam logic [3:0] OP_LUI    = 4'd5;
    localparam logic [3:0] OP_AUIPC  = 4'd6;
    localparam logic [3:0] OP_JALR   = 4'd7;
    localparam logic [3:0] OP_JAL    = 4'd8;

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       word;
    logic              legal;
    logic              accept;
    logic              at_last;

    assign accept  = in_valid & in_ready;
    assign at_last = (ptr == LAST_ADDR);
    assign full    = (state == S_FULL);

    // Encode the request into an instruction word and classify it as legal or not
    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (in_op)
            OP_LOAD:   word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
            OP_STORE:  word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
            OP_RTYPE:  word = {1'b0, in_f7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            OP_BRANCH: begin
                word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], 7'b1100011};
                legal = (in_funct3[2:1] != 2'b01);
            end
            OP_ITYPE: begin
                // Shift-immediates carry funct7 in the upper immediate bits
                if (in_funct3[1:0] == 2'b01)
                    word = {1'b0, in_f7b5, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
                else
                    word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
            end
            OP_LUI:    word = {in_imm[31:12], in_rd, 7'b0110111};
            OP_AUIPC:  word = {in_imm[31:12], in_rd, 7'b0010111};
            OP_JALR:   word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
            OP_JAL:    word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
            default:   legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // Next-state and handshake logic; start re-arms from any state
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        if (start) begin
            next_state = S_RUN;
        end else begin
            case (state)
                S_RUN: begin
                    in_ready = 1'b1;
                    if (in_valid && legal && at_last)
                        next_state = S_FULL;
                end
                default: next_state = state;
            endcase
        end
    end

    // Write port, pointer, count and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ptr       <= '0;
            count     <= '0;
            err       <= 1'b0;
        end else begin
            mem_we <= accept & legal;
            if (accept && legal) begin
                mem_addr  <= ptr;
                mem_wdata <= word;
            end
            if (start) begin
                ptr   <= BASE;
                count <= '0;
                err   <= 1'b0;
            end else if (accept) begin
                if (legal) begin
                    if (!at_last)
                        ptr <= ptr + 1'b1;
                    count <= count + 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder
module tb_instr_encoder;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [2:0]        in_funct3;
    logic              in_f7b5;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;

    int checks = 0;
    int errors = 0;
    logic [ADDR_W+31:0] sb[$];
    logic [ADDR_W-1:0]  exp_ptr = '0;

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe pops the oldest expected {addr,word}
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mem_we === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0d data 0x%08h with empty scoreboard", mem_addr, mem_wdata);
                end else begin
                    logic [ADDR_W+31:0] e;
                    e = sb.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(e[ADDR_W+31:32]));
                    check("wr_data", mem_wdata, e[31:0]);
                end
            end
        end
    end

    // Present one request (left valid) and register its expected write on acceptance
    task automatic send(input logic [3:0] op, input logic [2:0] f3, input logic f7b5,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic legal, input logic [31:0] exp_word);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_funct3 = f3; in_f7b5 = f7b5;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        #1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: in_ready %b expected 1", in_ready);
        end else if (legal) begin
            sb.push_back({exp_ptr, exp_word});
            exp_ptr = exp_ptr + 1'b1;
        end
    endtask

    task automatic idle(input int cycles);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_ptr = '0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_op = '0; in_funct3 = '0;
        in_f7b5 = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(in_ready), 0);
        check("rst_we", 32'(mem_we), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_count", 32'(count), 0);
        check("rst_full", 32'(full), 0);
        check("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(in_ready), 0);

        // Directed encodings
        pulse_start();
        send(4'd4, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,          1'b1, 32'h00500093);
        send(4'd1, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,          1'b1, 32'h0020A423);
        send(4'd3, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,   1'b1, 32'hFE208EE3);
        send(4'd2, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,          1'b1, 32'h402081B3);
        send(4'd8, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8,          1'b1, 32'h008000EF);
        send(4'd5, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000,   1'b1, 32'h123452B7);
        send(4'd6, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'h00001000,   1'b1, 32'h00001117);
        send(4'd7, 3'b011, 1'b0, 5'd1, 5'd5, 5'd0, 32'd4,          1'b1, 32'h004280E7);
        send(4'd4, 3'b101, 1'b1, 5'd3, 5'd4, 5'd0, 32'h00000FFF,   1'b1, 32'h41F25193);
        send(4'd0, 3'b010, 1'b0, 5'd6, 5'd2, 5'd0, 32'hFFFFFFFF,   1'b1, 32'hFFF12303);
        idle(3);
        check("count_10", 32'(count), 10);
        check("err_clean", 32'(err), 0);

        // Illegal requests are consumed without a write
        send(4'd9, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 32'd0);
        send(4'd3, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'd0);
        idle(3);
        check("err_set", 32'(err), 1);
        check("count_hold", 32'(count), 10);
        send(4'd4, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093);
        idle(3);
        check("count_11", 32'(count), 11);
        check("err_sticky", 32'(err), 1);
        pulse_start();
        check("err_cleared", 32'(err), 0);
        check("count_cleared", 32'(count), 0);

        // Start while valid and a write is in flight
        send(4'd4, 3'b000, 1'b0, 5'd7, 5'd0, 5'd0, 32'd1, 1'b1, 32'h00100393);
        @(negedge clk);
        start = 1'b1;
        in_imm = 32'd2;
        #1;
        check("start_blocks_ready", 32'(in_ready), 0);
        @(negedge clk);
        start = 1'b0;
        exp_ptr = '0;
        in_valid = 1'b0;
        send(4'd4, 3'b000, 1'b0, 5'd7, 5'd0, 5'd0, 32'd3, 1'b1, 32'h00300393);
        idle(3);
        check("after_start_count", 32'(count), 1);

        // Fill all 64 words back to back
        pulse_start();
        for (int i = 0; i < 64; i++) begin
            logic [31:0] w;
            w = (32'(i) << 20) | 32'h00000093;
            send(4'd4, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'(i), 1'b1, w);
        end
        @(negedge clk);
        #1;
        check("full_ready", 32'(in_ready), 0);
        check("full_flag", 32'(full), 1);
        check("full_count", 32'(count), 64);
        repeat (3) @(negedge clk);
        check("full_ready_hold", 32'(in_ready), 0);
        check("full_count_hold", 32'(count), 64);
        in_valid = 1'b0;

        // Drain scoreboard
        for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
